// File: rtl/load_pkg.sv
// Types shared by the load path: access sizes, load-unit FSM states and size decoding.
package load_pkg;

    typedef enum logic [1:0] {
        LS_BYTE   = 2'd0,
        LS_HALF   = 2'd1,
        LS_WORD   = 2'd2,
        LS_DOUBLE = 2'd3
    } load_size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_RESP   = 3'd5,
        ST_DRAIN  = 3'd6
    } load_state_e;

    function automatic int unsigned size_bytes(load_size_e size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational merge of one or two bus beats into a right-aligned, sign/zero-extended value.
module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int BYTES = XLEN / 8,
    localparam int OFF_W = $clog2(BYTES)
) (
    input  logic [XLEN-1:0]  beat0_i,
    input  logic [XLEN-1:0]  beat1_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [1:0]       size_i,
    input  logic             signed_i,
    input  logic             split_i,
    output logic [XLEN-1:0]  data_o
);
    localparam int SH_W  = $clog2(XLEN) + 1;
    localparam int IDX_W = $clog2(XLEN);

    logic [XLEN-1:0]  raw;
    logic [XLEN-1:0]  keep_mask;
    logic [SH_W-1:0]  nbits;
    logic [SH_W-1:0]  hi_shift;
    logic [IDX_W-1:0] lo_shift;
    logic [IDX_W-1:0] sign_idx;

    always_comb begin
        lo_shift = {off_i, 3'b000};
        hi_shift = SH_W'(XLEN) - SH_W'(lo_shift);
        raw      = beat0_i >> lo_shift;
        if (split_i) begin
            raw = raw | (beat1_i << hi_shift);
        end
        // An access as wide as the bus (or wider) is a plain pass-through.
        if (size_bytes(load_size_e'(size_i)) >= BYTES) begin
            nbits = SH_W'(XLEN);
        end else begin
            nbits = SH_W'(8 * size_bytes(load_size_e'(size_i)));
        end
        keep_mask = (nbits == SH_W'(XLEN)) ? '1 : ~({XLEN{1'b1}} << nbits);
        sign_idx  = IDX_W'(nbits - SH_W'(1));
        data_o    = raw & keep_mask;
        if (signed_i && raw[sign_idx]) begin
            data_o = data_o | ~keep_mask;
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// Load unit between MEM and the data-memory port: issues one or two aligned reads,
// merges the beats and returns the right-aligned, extended result on a valid/ready channel.
module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_req_addr,
    input  logic             mem_resp_valid,
    input  logic [XLEN-1:0]  mem_resp_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_split,
    output logic             load_stall,
    input  logic             flush
);
    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam logic [XLEN-1:0] BASE_MASK = ~XLEN'(BYTES - 1);
    localparam logic [XLEN-1:0] WORD_STEP = XLEN'(BYTES);

    load_state_e      state_q, state_d;
    logic [XLEN-1:0]  addr_q, beat0_q, resp_data_q;
    logic [XLEN-1:0]  mem_req_addr_q, mem_req_addr_d;
    load_size_e       size_q;
    logic             signed_q, split_q;
    logic [TAG_W-1:0] tag_q;
    logic             req_ready_q, mem_req_valid_q, resp_valid_q, load_stall_q;
    logic             accept, req_split;
    logic [XLEN-1:0]  ext_beat0, ext_data;

    assign accept    = (state_q == ST_IDLE) && req_valid && !flush;
    assign req_split = (int'(req_addr[OFF_W-1:0]) + int'(size_bytes(load_size_e'(req_size)))) > BYTES;
    // A non-split load completes straight out of WAIT0, before beat0_q has been written.
    assign ext_beat0 = (state_q == ST_WAIT0) ? mem_resp_data : beat0_q;

    load_extract #(.XLEN(XLEN)) u_extract (
        .beat0_i  (ext_beat0),
        .beat1_i  (mem_resp_data),
        .off_i    (addr_q[OFF_W-1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .split_i  (split_q),
        .data_o   (ext_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_ISSUE0;
            // A flushed issue the bus still accepted leaves a response to swallow.
            ST_ISSUE0: if (flush) state_d = mem_req_ready ? ST_DRAIN : ST_IDLE;
                       else if (mem_req_ready) state_d = ST_WAIT0;
            ST_WAIT0:  if (flush) state_d = mem_resp_valid ? ST_IDLE : ST_DRAIN;
                       else if (mem_resp_valid) state_d = split_q ? ST_ISSUE1 : ST_RESP;
            ST_ISSUE1: if (flush) state_d = mem_req_ready ? ST_DRAIN : ST_IDLE;
                       else if (mem_req_ready) state_d = ST_WAIT1;
            ST_WAIT1:  if (flush) state_d = mem_resp_valid ? ST_IDLE : ST_DRAIN;
                       else if (mem_resp_valid) state_d = ST_RESP;
            ST_RESP:   if (flush || resp_ready) state_d = ST_IDLE;
            ST_DRAIN:  if (mem_resp_valid) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_ISSUE0: mem_req_addr_d = ((state_q == ST_IDLE) ? req_addr : addr_q) & BASE_MASK;
            ST_ISSUE1: mem_req_addr_d = (addr_q & BASE_MASK) + WORD_STEP;
            default:   mem_req_addr_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            load_stall_q    <= 1'b0;
            addr_q          <= '0;
            size_q          <= LS_BYTE;
            signed_q        <= 1'b0;
            split_q         <= 1'b0;
            tag_q           <= '0;
            beat0_q         <= '0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= (state_d == ST_IDLE);
            mem_req_valid_q <= (state_d == ST_ISSUE0) || (state_d == ST_ISSUE1);
            mem_req_addr_q  <= mem_req_addr_d;
            resp_valid_q    <= (state_d == ST_RESP);
            load_stall_q    <= (state_d != ST_IDLE);
            if (accept) begin
                addr_q   <= req_addr;
                size_q   <= load_size_e'(req_size);
                signed_q <= req_signed;
                split_q  <= req_split;
                tag_q    <= req_tag;
            end
            if ((state_q == ST_WAIT0) && mem_resp_valid) begin
                beat0_q <= mem_resp_data;
            end
            if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
                resp_data_q <= ext_data;
            end
        end
    end

    assign req_ready     = req_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_tag      = tag_q;
    assign resp_split    = split_q;
    assign load_stall    = load_stall_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: byte-addressed memory model, directed scenarios, randomized loads.
module tb_load_align_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [4:0]  req_tag;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [4:0]  resp_tag;
    logic        resp_split;
    logic        load_stall;
    logic        flush;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [logic [63:0]];
    logic [63:0] bus_log [$];
    int          ready_low = 0;
    int          resp_delay = 0;
    bit          hs, rst_s, pend;
    logic [63:0] hs_addr, pend_addr;
    int          pend_cnt;

    load_align_unit #(.XLEN(64), .TAG_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_tag        (req_tag),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_tag       (resp_tag),
        .resp_split     (resp_split),
        .load_stall     (load_stall),
        .flush          (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=no_finish required=finish");
        $fatal(1, "simulation timeout");
    end

    function automatic logic [7:0] rd_byte(input logic [63:0] a);
        logic [63:0] h;
        if (mem.exists(a)) return mem[a];
        h = a * 64'h9E37_79B9_7F4A_7C15;
        return h[63:56];
    endfunction

    function automatic logic [63:0] rd_word(input logic [63:0] a);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = rd_byte(a + 64'(i));
        return w;
    endfunction

    task automatic set_word(input logic [63:0] a, input logic [63:0] w);
        for (int i = 0; i < 8; i++) mem[a + 64'(i)] = w[8*i +: 8];
    endtask

    // Reference: gather n consecutive bytes little-endian, then extend arithmetically.
    function automatic logic [63:0] model_load(input logic [63:0] a, input int n, input bit sgn);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(rd_byte(a + 64'(i))) << (8 * i));
        if (sgn && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        check({p, "_req_ready"},  64'(req_ready),     64'd1);
        check({p, "_mreq_valid"}, 64'(mem_req_valid), 64'd0);
        check({p, "_mreq_addr"},  mem_req_addr,       64'd0);
        check({p, "_resp_valid"}, 64'(resp_valid),    64'd0);
        check({p, "_resp_data"},  resp_data,          64'd0);
        check({p, "_resp_tag"},   64'(resp_tag),      64'd0);
        check({p, "_resp_split"}, 64'(resp_split),    64'd0);
        check({p, "_load_stall"}, 64'(load_stall),    64'd0);
    endtask

    // Memory: handshake seen mid-cycle, response driven resp_delay cycles after the accepting edge.
    initial begin
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        pend = 1'b0;
        pend_cnt = 0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            hs      = mem_req_valid && mem_req_ready && !reset;
            rst_s   = reset;
            hs_addr = mem_req_addr;
            if (hs) bus_log.push_back(mem_req_addr);
            if (mem_req_valid && !mem_req_ready && ready_low > 0) ready_low--;
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (rst_s) pend = 1'b0;
            if (hs) begin
                pend      = 1'b1;
                pend_addr = hs_addr;
                pend_cnt  = resp_delay;
            end
            if (pend) begin
                if (pend_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = rd_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            mem_req_ready = (ready_low == 0);
        end
    end

    task automatic run_load(input logic [63:0] addr, input logic [1:0] sz, input bit sgn,
                            input logic [4:0] tag, input int hold, input bit chk_lat,
                            output logic [63:0] got, output int lat);
        logic [63:0] exp_d, base, held, prev_addr;
        bit          exp_split, prev_mrv;
        int          n, prev_log;
        n         = 1 << sz;
        exp_split = (int'(addr[2:0]) + n) > 8;
        exp_d     = model_load(addr, n, sgn);
        base      = {addr[63:3], 3'b000};
        bus_log.delete();
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_addr = addr; req_size = sz; req_signed = sgn; req_tag = tag;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_size = 2'($urandom);
        req_signed = 1'($urandom); req_tag = 5'($urandom);
        lat = 1; prev_mrv = 1'b0; prev_addr = '0; prev_log = 0;
        while (!resp_valid && lat < 100) begin
            check("stall_busy", 64'(load_stall), 64'd1);
            check("req_ready_busy", 64'(req_ready), 64'd0);
            if (prev_mrv && bus_log.size() == prev_log) begin
                check("mreq_valid_hold", 64'(mem_req_valid), 64'd1);
                check("mreq_addr_hold", mem_req_addr, prev_addr);
            end
            prev_mrv = mem_req_valid; prev_addr = mem_req_addr; prev_log = bus_log.size();
            @(posedge clk); #1;
            lat++;
        end
        check("resp_arrives", 64'(resp_valid), 64'd1);
        if (chk_lat) check("latency", 64'(lat), exp_split ? 64'd5 : 64'd3);
        check("bus_reads", 64'(bus_log.size()), exp_split ? 64'd2 : 64'd1);
        if (bus_log.size() > 0) check("rd0_addr", bus_log[0], base);
        if (bus_log.size() > 1) check("rd1_addr", bus_log[1], base + 64'd8);
        check("data", resp_data, exp_d);
        check("tag", 64'(resp_tag), 64'(tag));
        check("split", 64'(resp_split), 64'(exp_split));
        got  = resp_data;
        held = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("resp_hold_valid", 64'(resp_valid), 64'd1);
            check("resp_hold_data", resp_data, held);
            check("resp_hold_stall", 64'(load_stall), 64'd1);
            check("resp_hold_noready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_done", 64'(resp_valid), 64'd0);
        check("idle_ready", 64'(req_ready), 64'd1);
        check("idle_stall", 64'(load_stall), 64'd0);
    endtask

    initial begin
        logic [63:0] a, got;
        int          lat, cnt, hold, sz;
        bit          sgn, seen;

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0; req_signed = 1'b0;
        req_tag = '0; resp_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        set_word(64'h1000, 64'h0000_0000_8000_0000);
        run_load(64'h1003, 2'd0, 1'b1, 5'd1, 0, 1'b1, got, lat);
        check("t1_data", got, 64'hFFFF_FFFF_FFFF_FF80);

        set_word(64'h2000, 64'hBBAA_0000_0000_0000);
        set_word(64'h2008, 64'h0000_0000_0000_DDCC);
        run_load(64'h2006, 2'd2, 1'b0, 5'd2, 0, 1'b1, got, lat);
        check("t2_data", got, 64'h0000_0000_DDCC_BBAA);
        check("t2_latency", 64'(lat), 64'd5);

        set_word(64'h3000, 64'h8123_4567_89AB_CDEF);
        run_load(64'h3000, 2'd3, 1'b1, 5'd3, 0, 1'b1, got, lat);
        check("t3_data", got, 64'h8123_4567_89AB_CDEF);

        ready_low = 4;
        run_load(64'h6002, 2'd1, 1'b1, 5'd4, 3, 1'b0, got, lat);
        check("t4_latency", 64'(lat), 64'd7);

        // Flush in WAIT0 of a split load, response one cycle late so DRAIN is exercised.
        resp_delay = 1;
        bus_log.delete();
        req_valid = 1'b1; req_addr = 64'h4005; req_size = 2'd2; req_signed = 1'b1; req_tag = 5'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cnt = 0;
        while (bus_log.size() == 0 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("f_first_read", 64'(bus_log.size()), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("f_drain_stall", 64'(load_stall), 64'd1);
        check("f_drain_noready", 64'(req_ready), 64'd0);
        check("f_drain_noresp", 64'(resp_valid), 64'd0);
        check("f_drain_noissue", 64'(mem_req_valid), 64'd0);
        @(posedge clk); #1;
        check("f_idle_ready", 64'(req_ready), 64'd1);
        check("f_idle_stall", 64'(load_stall), 64'd0);
        seen = 1'b0;
        repeat (4) begin
            if (resp_valid || mem_req_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("f_quiet", 64'(seen), 64'd0);
        check("f_one_read", 64'(bus_log.size()), 64'd1);
        resp_delay = 0;

        // Reset while waiting for the second beat.
        resp_delay = 2;
        bus_log.delete();
        req_valid = 1'b1; req_addr = 64'h5006; req_size = 2'd2; req_signed = 1'b0; req_tag = 5'd6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cnt = 0;
        while (bus_log.size() < 2 && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("r_in_wait1", 64'(bus_log.size()), 64'd2);
        check("r_busy", 64'(load_stall), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset("r_wait1");
        resp_delay = 0;
        seen = 1'b0;
        repeat (4) begin
            if (resp_valid || mem_req_valid || load_stall) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("r_quiet", 64'(seen), 64'd0);
        run_load(64'h5006, 2'd2, 1'b0, 5'd7, 0, 1'b1, got, lat);

        for (int k = 0; k < 40; k++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) a = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            sz         = $urandom_range(0, 3);
            sgn        = 1'($urandom);
            hold       = $urandom_range(0, 2);
            ready_low  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            resp_delay = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
            run_load(a, 2'(sz), sgn, 5'($urandom), hold, (ready_low == 0) && (resp_delay == 0), got, lat);
        end
        resp_delay = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
